// File: rtl/req_tracker_if.sv
// req_tracker_if: request/grant handshake bundle between an agent-side driver
// and the req_tracker endpoint. The driver side (master) supplies pushes and
// the selector's grant; the tracker side (slave) returns the pending-request
// vector, occupancy flags, issue reports, error flag and starvation flags.
interface req_tracker_if #(
    parameter int N = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  push;
    logic          en;
    logic [N-1:0]  gnt;
    logic [N-1:0]  req;
    logic [N-1:0]  full;
    logic          issue_valid;
    logic [IW-1:0] issue_idx;
    logic          gnt_err;
    logic [N-1:0]  starve;

    modport master (
        output push, en, gnt,
        input  req, full, issue_valid, issue_idx, gnt_err, starve
    );

    modport slave (
        input  push, en, gnt,
        output req, full, issue_valid, issue_idx, gnt_err, starve
    );
endinterface

// File: rtl/req_tracker.sv
// req_tracker: requester-side endpoint of the rotating priority-select
// handshake. Keeps a pending-request count per agent, presents req/full to
// the selector, retires one request per consumed grant and reports each
// grant one cycle later as an encoded issue event. Malformed grants raise a
// sticky error flag.
//
// Optional feature: define REQ_TRACKER_STARVE_EN to build the per-agent wait
// counters that drive the starve outputs; otherwise starve is tied to zero.
module req_tracker #(
    parameter int N            = 8,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic           clock,
    input  logic           reset,
    req_tracker_if.slave   bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    logic          issueValid_q, issueValid_d;
    logic [IW-1:0] issueIdx_q,   issueIdx_d;
    logic          gntErr_q,     gntErr_d;

    logic [N-1:0]  reqVec;
    logic [N-1:0]  fullVec;
    logic          multiGnt;
    logic [N-1:0]  consume;
    logic [N-1:0]  idleGnt;
    logic [N-1:0]  accept;
    logic [IW-1:0] grantIdx;

    // Occupancy flags come straight from the count registers so the
    // selector never sees a combinational path from this cycle's inputs.
    always_comb begin
        reqVec  = '0;
        fullVec = '0;
        for (int i = 0; i < N; i++) begin
            reqVec[i]  = (cnt_q[i] != '0);
            fullVec[i] = (cnt_q[i] == DEPTH_C);
        end
    end

    assign bus.req  = reqVec;
    assign bus.full = fullVec;

    // Grant qualification: a multi-hot grant freezes every count for the
    // cycle; a single grant only retires a request if the agent has one.
    // A full agent may still accept a push in the same cycle it is drained.
    always_comb begin
        multiGnt = bus.en && ((bus.gnt & (bus.gnt - N'(1))) != '0);
        consume  = (bus.en && !multiGnt) ? (bus.gnt & reqVec) : '0;
        idleGnt  = bus.en ? (bus.gnt & ~reqVec) : '0;
        accept   = multiGnt ? '0 : (bus.push & (~fullVec | consume));
    end

    // Per-agent count update: push and consume in the same cycle cancel.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept[i] && !consume[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (!accept[i] && consume[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    // One-hot to binary encoding of the grant; only used when exactly one
    // bit is set and that agent had a pending request.
    always_comb begin
        grantIdx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.gnt[i]) begin
                grantIdx = IW'(i);
            end
        end
    end

    // Issue report and sticky protocol-error flag; the index holds its
    // previous value between issue pulses.
    always_comb begin
        issueValid_d = |consume;
        issueIdx_d   = issueIdx_q;
        if (|consume) begin
            issueIdx_d = grantIdx;
        end
        gntErr_d = gntErr_q | multiGnt | (|idleGnt);
    end

    // State registers; everything clears immediately while reset is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
            issueValid_q <= 1'b0;
            issueIdx_q   <= '0;
            gntErr_q     <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            issueValid_q <= issueValid_d;
            issueIdx_q   <= issueIdx_d;
            gntErr_q     <= gntErr_d;
        end
    end

    assign bus.issue_valid = issueValid_q;
    assign bus.issue_idx   = issueIdx_q;
    assign bus.gnt_err     = gntErr_q;

`ifdef REQ_TRACKER_STARVE_EN
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] LIMIT_C = WW'(STARVE_LIMIT);

    logic [WW-1:0] wait_q [N];
    logic [WW-1:0] wait_d [N];
    logic [N-1:0]  starveVec;

    // Wait counters measure how long a pending agent has gone unserved;
    // they restart on service or when the agent goes idle and saturate.
    always_comb begin
        starveVec = '0;
        for (int i = 0; i < N; i++) begin
            wait_d[i] = wait_q[i];
            if (consume[i] || !reqVec[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != LIMIT_C) begin
                wait_d[i] = wait_q[i] + WW'(1);
            end
            starveVec[i] = (wait_q[i] == LIMIT_C);
        end
    end

    // Wait counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    assign bus.starve = starveVec;
`else
    assign bus.starve = '0;
`endif

endmodule

// File: tb/tb_req_tracker.sv
// tb_req_tracker: directed scenarios with literal expectations followed by
// randomized traffic, all compared every cycle against a count-based model
// of the request tracker. Honours REQ_TRACKER_STARVE_EN like the design.
module tb_req_tracker;
    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int LIMIT = 15;
`ifdef REQ_TRACKER_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;

    int errors = 0;
    int checks = 0;
    bit checkOn = 1'b0;

    req_tracker_if #(.N(N)) bus ();

    req_tracker #(
        .N(N),
        .DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Reference model state: plain integer counts and wait ages per agent.
    int mCnt  [N];
    int mWait [N];
    bit mIv;
    int mIdx;
    bit mErr;

    initial begin
        for (int i = 0; i < N; i++) begin
            mCnt[i]  = 0;
            mWait[i] = 0;
        end
        mIv  = 1'b0;
        mIdx = 0;
        mErr = 1'b0;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: counts follow the tracker's rules stated in terms of
    // how many grant bits are set and whether the granted agent has work.
    always @(posedge clock or negedge reset) begin : modelUpdate
        int ones;
        int g;
        bit took;
        int old;
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                mCnt[i]  = 0;
                mWait[i] = 0;
            end
            mIv  = 1'b0;
            mIdx = 0;
            mErr = 1'b0;
        end else begin
            ones = bus.en ? $countones(bus.gnt) : 0;
            g = -1;
            if (ones == 1) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.gnt[i]) g = i;
                end
            end
            took = (g >= 0) && (mCnt[g] > 0);
            if (ones > 1 || (g >= 0 && !took)) mErr = 1'b1;
            for (int i = 0; i < N; i++) begin
                old = mCnt[i];
                if (old == 0 || (took && g == i)) mWait[i] = 0;
                else if (mWait[i] < LIMIT) mWait[i] = mWait[i] + 1;
                if (ones <= 1) begin
                    if (took && g == i) mCnt[i] = mCnt[i] - 1;
                    if (bus.push[i] && (old < DEPTH || (took && g == i))) mCnt[i] = mCnt[i] + 1;
                end
            end
            mIv = took;
            if (took) mIdx = g;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin : compare
        logic [N-1:0] eReq, eFull, eStv;
        if (checkOn) begin
            for (int i = 0; i < N; i++) begin
                eReq[i]  = (mCnt[i] > 0);
                eFull[i] = (mCnt[i] == DEPTH);
                eStv[i]  = STARVE_ON && (mWait[i] == LIMIT);
            end
            checkOutput("cmp_req", 32'(bus.req), 32'(eReq));
            checkOutput("cmp_full", 32'(bus.full), 32'(eFull));
            checkOutput("cmp_issue_valid", 32'(bus.issue_valid), 32'(mIv));
            checkOutput("cmp_issue_idx", 32'(bus.issue_idx), 32'(mIdx));
            checkOutput("cmp_gnt_err", 32'(bus.gnt_err), 32'(mErr));
            checkOutput("cmp_starve", 32'(bus.starve), 32'(eStv));
        end
    end

    task automatic applyStimulus(input logic [N-1:0] p, input logic e, input logic [N-1:0] g);
        @(negedge clock);
        bus.push = p;
        bus.en   = e;
        bus.gnt  = g;
        @(posedge clock);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req"}, 32'(bus.req), 32'h0);
        checkOutput({tag, "_full"}, 32'(bus.full), 32'h0);
        checkOutput({tag, "_issue_valid"}, 32'(bus.issue_valid), 32'h0);
        checkOutput({tag, "_issue_idx"}, 32'(bus.issue_idx), 32'h0);
        checkOutput({tag, "_gnt_err"}, 32'(bus.gnt_err), 32'h0);
        checkOutput({tag, "_starve"}, 32'(bus.starve), 32'h0);
    endtask

    task automatic midCycleReset(input string tag);
        @(negedge clock);
        bus.push = '0;
        bus.en   = 1'b0;
        bus.gnt  = '0;
        #2;
        reset = 1'b0;
        #1;
        checkResetOutputs(tag);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin : stimulus
        logic [N-1:0] p, g;
        logic e;
        int pend [$];
        int r, a, b;

        bus.push = '0;
        bus.en   = 1'b0;
        bus.gnt  = '0;

        #12;
        checkResetOutputs("reset");
        @(negedge clock);
        reset   = 1'b1;
        checkOn = 1'b1;

        // Single push / single grant to agent 3.
        applyStimulus(8'h08, 1'b0, 8'h00);
        checkOutput("push3_req", 32'(bus.req), 32'h08);
        checkOutput("push3_full", 32'(bus.full), 32'h00);
        applyStimulus(8'h00, 1'b1, 8'h08);
        checkOutput("gnt3_valid", 32'(bus.issue_valid), 32'h1);
        checkOutput("gnt3_idx", 32'(bus.issue_idx), 32'h3);
        checkOutput("gnt3_req", 32'(bus.req), 32'h00);
        applyStimulus(8'h00, 1'b0, 8'h00);
        checkOutput("gnt3_pulse_end", 32'(bus.issue_valid), 32'h0);

        // Fill agent 0 past depth, then drain with four grants.
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(8'h01, 1'b0, 8'h00);
            if (k == 3) checkOutput("fill0_not_full", 32'(bus.full), 32'h00);
            if (k == 4) checkOutput("fill0_full", 32'(bus.full), 32'h01);
        end
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(8'h00, 1'b1, 8'h01);
            checkOutput("drain0_valid", 32'(bus.issue_valid), 32'h1);
            checkOutput("drain0_idx", 32'(bus.issue_idx), 32'h0);
            if (k == 3) checkOutput("drain0_req_left", 32'(bus.req), 32'h01);
            if (k == 4) checkOutput("drain0_req_empty", 32'(bus.req), 32'h00);
        end
        applyStimulus(8'h00, 1'b0, 8'h00);

        // Full agent 5 with a simultaneous push and grant stays full.
        for (int k = 0; k < 4; k++) applyStimulus(8'h20, 1'b0, 8'h00);
        checkOutput("fill5_full", 32'(bus.full), 32'h20);
        applyStimulus(8'h20, 1'b1, 8'h20);
        checkOutput("pg5_full", 32'(bus.full), 32'h20);
        checkOutput("pg5_idx", 32'(bus.issue_idx), 32'h5);
        checkOutput("pg5_valid", 32'(bus.issue_valid), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(8'h00, 1'b1, 8'h20);
            if (k == 3) checkOutput("drain5_req_left", 32'(bus.req), 32'h20);
            if (k == 4) checkOutput("drain5_req_empty", 32'(bus.req), 32'h00);
        end

        // Grant to an idle agent, then a multi-hot grant.
        applyStimulus(8'h00, 1'b1, 8'h02);
        checkOutput("idle_err", 32'(bus.gnt_err), 32'h1);
        checkOutput("idle_no_issue", 32'(bus.issue_valid), 32'h0);
        applyStimulus(8'h01, 1'b0, 8'h00);
        applyStimulus(8'h00, 1'b1, 8'h01);
        checkOutput("clean_err_sticky", 32'(bus.gnt_err), 32'h1);
        checkOutput("clean_valid", 32'(bus.issue_valid), 32'h1);
        applyStimulus(8'h06, 1'b0, 8'h00);
        checkOutput("multi_pre_req", 32'(bus.req), 32'h06);
        applyStimulus(8'h00, 1'b1, 8'h06);
        checkOutput("multi_req_kept", 32'(bus.req), 32'h06);
        checkOutput("multi_no_issue", 32'(bus.issue_valid), 32'h0);
        checkOutput("multi_err", 32'(bus.gnt_err), 32'h1);
        applyStimulus(8'h00, 1'b1, 8'h02);
        checkOutput("after_multi_req", 32'(bus.req), 32'h04);
        applyStimulus(8'h00, 1'b1, 8'h04);
        checkOutput("after_multi_err", 32'(bus.gnt_err), 32'h1);

        // All agents full, one issued, then reset pulled low mid-cycle.
        for (int k = 0; k < 4; k++) applyStimulus(8'hFF, 1'b0, 8'h00);
        applyStimulus(8'h00, 1'b1, 8'h40);
        checkOutput("pre_reset_full", 32'(bus.full), 32'hBF);
        checkOutput("pre_reset_idx", 32'(bus.issue_idx), 32'h6);
        midCycleReset("async_reset");

        // Starvation of agent 2.
        applyStimulus(8'h04, 1'b0, 8'h00);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(8'h00, 1'b0, 8'h00);
            if (k == 14) checkOutput("starve_early", 32'(bus.starve), 32'h00);
            if (k >= 15) checkOutput("starve_set", 32'(bus.starve), STARVE_ON ? 32'h04 : 32'h00);
        end
        applyStimulus(8'h00, 1'b1, 8'h04);
        checkOutput("starve_clear", 32'(bus.starve), 32'h00);
        checkOutput("starve_gnt_idx", 32'(bus.issue_idx), 32'h2);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                midCycleReset("rand_reset");
            end
            pend.delete();
            for (int i = 0; i < N; i++) if (mCnt[i] > 0) pend.push_back(i);
            p = N'($urandom_range(0, 255)) & N'($urandom_range(0, 255));
            e = ($urandom_range(0, 3) != 0);
            g = '0;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                if (pend.size() > 0) g[pend[$urandom_range(0, pend.size() - 1)]] = 1'b1;
            end else if (r < 80) begin
                g = '0;
            end else if (r < 84) begin
                a = $urandom_range(0, N - 1);
                b = (a + $urandom_range(1, N - 1)) % N;
                g[a] = 1'b1;
                g[b] = 1'b1;
                p = '0;
            end else begin
                g[$urandom_range(0, N - 1)] = 1'b1;
            end
            applyStimulus(p, e, g);
        end

        applyStimulus(8'h00, 1'b0, 8'h00);
        checkOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
